pc_sequencer: RTL

//  Program-counter/fetch sequencer sitting directly downstream of the branch comparator.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer_branch_target_calc.sv | 20 ++
 rtl/pc_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants, state type and helpers for the program-counter/fetch sequencer.
package pc_sequencer_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPC_W     = 6;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [OPC_W-1:0] OPC_J    = 6'h02;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_BNE  = 6'h09;
  localparam logic [OPC_W-1:0] OPC_BLEZ = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_BGTZ = 6'h0B;
  localparam logic [OPC_W-1:0] OPC_BGE  = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_BLT  = 6'h0D;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } seq_state_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/fetch/branch-decision signal bundle between the sequencer and its neighbours.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall_i;
  logic             ir_valid_i;
  logic [31:0]      ir_i;
  logic [31:0]      ir_pc_i;
  logic             branch_yes_i;
  logic             imem_ready_i;
  logic [31:0]      pc_o;
  logic             imem_req_o;
  logic             flush_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  modport master (
    input  stall_i, ir_valid_i, ir_i, ir_pc_i, branch_yes_i, imem_ready_i,
    output pc_o, imem_req_o, flush_o, redirect_cnt_o
  );

  modport slave (
    output stall_i, ir_valid_i, ir_i, ir_pc_i, branch_yes_i, imem_ready_i,
    input  pc_o, imem_req_o, flush_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// Combinational branch and jump target computation from the decoded instruction.
module branch_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  input  logic [XLEN-1:0] ir_pc_i,
  output logic [XLEN-1:0] br_tgt,
  output logic [XLEN-1:0] j_tgt
);

  logic [XLEN-1:0] seq_pc;
  logic            unused_opc;

  assign seq_pc     = ir_pc_i + XLEN'(4);
  assign br_tgt     = seq_pc + (sext16(ir_i[15:0]) << 2);
  assign j_tgt      = {seq_pc[31:28], ir_i[25:0], 2'b00};
  // Opcode is decoded by the sequencer, not here.
  assign unused_opc = ^ir_i[31:26];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: decodes branches/jumps, waits for the comparator decision,
// redirects fetch, flushes the shadow slot and counts redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [5:0]  OPC_BR_LO = 6'h08,
  parameter logic [5:0]  OPC_BR_HI = 6'h0D,
  parameter logic [5:0]  OPC_J     = 6'h02,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  localparam int unsigned WA_W = XLEN - 2;

  seq_state_t       state_q, state_d;
  logic [WA_W-1:0]  pc_q, pc_d;
  logic [WA_W-1:0]  tgt_q, tgt_d;
  logic             req_q, req_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  br_tgt, j_tgt;
  logic [OPC_W-1:0] opc;
  logic             ir_live, is_br, is_j, fire, redirect;
  logic             unused_lsb;

  branch_target_calc u_btc (
    .ir_i    (bus.ir_i),
    .ir_pc_i (bus.ir_pc_i),
    .br_tgt  (br_tgt),
    .j_tgt   (j_tgt)
  );

  // PC is kept word-aligned, so target byte offsets are dropped.
  assign unused_lsb = ^{br_tgt[1:0], j_tgt[1:0]};

  // The instruction behind a redirect (flush_q high) is the shadow and is never decoded.
  assign opc     = bus.ir_i[31:26];
  assign ir_live = bus.ir_valid_i && !flush_q && !bus.stall_i && (state_q == RUN);
  assign is_br   = ir_live && (opc >= OPC_BR_LO) && (opc <= OPC_BR_HI);
  assign is_j    = ir_live && (opc == OPC_J);
  assign fire    = req_q && bus.imem_ready_i && !bus.stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.stall_i) begin
      case (state_q)
        RUN:     if (is_br) state_d = BR_WAIT;
        BR_WAIT: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Next values of PC, target, request, flush and counter.
  always_comb begin
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    req_d    = req_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    redirect = 1'b0;
    if (!bus.stall_i) begin
      flush_d = 1'b0;
      req_d   = (state_d == RUN);
      case (state_q)
        RUN: begin
          if (fire)  pc_d  = pc_q + WA_W'(1);
          if (is_br) tgt_d = br_tgt[XLEN-1:2];
          if (is_j) begin
            pc_d     = j_tgt[XLEN-1:2];
            redirect = 1'b1;
          end
        end
        BR_WAIT: begin
          if (bus.branch_yes_i) begin
            pc_d     = tgt_q;
            redirect = 1'b1;
          end
        end
        default: ;
      endcase
      if (redirect) begin
        flush_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC[XLEN-1:2];
      tgt_q   <= '0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_o           = {pc_q, 2'b00};
  assign bus.imem_req_o     = req_q && !bus.stall_i;
  assign bus.flush_o        = flush_q;
  assign bus.redirect_cnt_o = cnt_q;

endmodule
